// File: rtl/simmem_row_scheduler.sv
// Single-bank DRAM access sequencer: arbitrates write/read address requests,
// tracks the open row and charges hit/activation/precharge latency per access.
//
// state | meaning
// IDLE  | waiting for a request; readies may assert
// SERVE | counting down the access cost of the accepted request
// DONE  | completion presented until done_ready_i
module simmem_row_scheduler #(
   parameter int GlobalMemCapaW = 19,
   parameter int RowBufLenW     = 10,
   parameter int RowHitCost     = 10,
   parameter int PrechargeCost  = 50,
   parameter int ActivationCost = 45,
   parameter int WIidW          = 5,
   parameter int RIidW          = 4,
   localparam int RowIdW = GlobalMemCapaW - RowBufLenW,
   localparam int IidW   = (WIidW > RIidW) ? WIidW : RIidW,
   localparam int CntW   = $clog2(PrechargeCost + ActivationCost + RowHitCost + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      w_valid_i,
   output logic                      w_ready_o,
   input  logic [GlobalMemCapaW-1:0] w_addr_i,
   input  logic [WIidW-1:0]          w_iid_i,
   input  logic                      r_valid_i,
   output logic                      r_ready_o,
   input  logic [GlobalMemCapaW-1:0] r_addr_i,
   input  logic [RIidW-1:0]          r_iid_i,
   output logic                      done_valid_o,
   input  logic                      done_ready_i,
   output logic                      done_is_read_o,
   output logic [IidW-1:0]           done_iid_o,
   output logic                      row_open_o,
   output logic [RowIdW-1:0]         open_row_o
);

   if (RowHitCost < 3) begin : g_cost_check
      $error("RowHitCost must be at least 3");
   end

   typedef enum logic [1:0] {IDLE, SERVE, DONE} state_e;

   localparam logic [CntW-1:0] HitCost    = CntW'(RowHitCost);
   localparam logic [CntW-1:0] ClosedCost = CntW'(ActivationCost + RowHitCost);
   localparam logic [CntW-1:0] MissCost   = CntW'(PrechargeCost + ActivationCost + RowHitCost);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q;
   logic                prio_q;            // 0 = write has priority, 1 = read
   logic                row_open_q;
   logic [RowIdW-1:0]   open_row_q;
   logic                is_read_q;
   logic [IidW-1:0]     iid_q;

   logic                w_grant, r_grant, accept;
   logic [RowIdW-1:0]   acc_row;
   logic [CntW-1:0]     cost;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{w_addr_i[RowBufLenW-1:0], r_addr_i[RowBufLenW-1:0]};

   always_comb begin
      state_d      = state_q;
      w_grant      = 1'b0;
      r_grant      = 1'b0;
      done_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            w_grant = w_valid_i & (~r_valid_i | ~prio_q);
            r_grant = r_valid_i & (~w_valid_i | prio_q);
            if (w_grant || r_grant) state_d = SERVE;
         end
         SERVE: begin
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            done_valid_o = 1'b1;
            if (done_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign w_ready_o = w_grant;
   assign r_ready_o = r_grant;
   assign accept    = w_grant | r_grant;
   assign acc_row   = r_grant ? r_addr_i[GlobalMemCapaW-1:RowBufLenW]
                              : w_addr_i[GlobalMemCapaW-1:RowBufLenW];

   always_comb begin
      cost = MissCost;
      if (!row_open_q)               cost = ClosedCost;
      else if (acc_row == open_row_q) cost = HitCost;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         prio_q     <= 1'b0;
         row_open_q <= 1'b0;
         open_row_q <= '0;
         is_read_q  <= 1'b0;
         iid_q      <= '0;
      end else if (accept) begin
         // two cycles of the cost are the accept edge and the SERVE->DONE edge
         cnt_q      <= cost - CntW'(2);
         prio_q     <= w_grant;
         row_open_q <= 1'b1;
         open_row_q <= acc_row;
         is_read_q  <= r_grant;
         iid_q      <= r_grant ? IidW'(r_iid_i) : IidW'(w_iid_i);
      end else if (state_q == SERVE && cnt_q != '0) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign done_is_read_o = is_read_q;
   assign done_iid_o     = iid_q;
   assign row_open_o     = row_open_q;
   assign open_row_o     = open_row_q;

endmodule

// File: tb/tb_simmem_row_scheduler.sv
// Directed self-checking bench for simmem_row_scheduler.
module tb_simmem_row_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_valid, w_ready, r_valid, r_ready;
   logic [18:0] w_addr, r_addr;
   logic [4:0]  w_iid;
   logic [3:0]  r_iid;
   logic        done_valid, done_ready, done_is_read;
   logic [4:0]  done_iid;
   logic        row_open;
   logic [8:0]  open_row;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   simmem_row_scheduler dut (
      .clk_i(clk), .rst_ni(rst_n),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_addr_i(w_addr), .w_iid_i(w_iid),
      .r_valid_i(r_valid), .r_ready_o(r_ready), .r_addr_i(r_addr), .r_iid_i(r_iid),
      .done_valid_o(done_valid), .done_ready_i(done_ready),
      .done_is_read_o(done_is_read), .done_iid_o(done_iid),
      .row_open_o(row_open), .open_row_o(open_row)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one request in IDLE, returns cycles from accept to done_valid
   // and the row status seen on the cycle after the accept.
   task automatic issue(input bit rd, input logic [18:0] a, input logic [4:0] id,
                        output int lat, output logic ro, output logic [8:0] orow);
      if (rd) begin
         r_valid = 1'b1; r_addr = a; r_iid = id[3:0];
      end else begin
         w_valid = 1'b1; w_addr = a; w_iid = id;
      end
      #1;
      chk("issue_ready", rd ? r_ready : w_ready, 1);
      tick;
      w_valid = 1'b0;
      r_valid = 1'b0;
      lat  = 1;
      ro   = row_open;
      orow = open_row;
      #1;
      while (!done_valid && lat < 300) begin
         tick;
         #1;
         lat++;
      end
   endtask

   int          lat;
   logic        ro;
   logic [8:0]  orow;
   int          n;
   bit          seen;

   initial begin
      rst_n = 1'b0; w_valid = 0; r_valid = 0; w_addr = '0; r_addr = '0;
      w_iid = '0; r_iid = '0; done_ready = 1'b1;
      repeat (3) tick;
      #1;
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_is_read", done_is_read, 0);
      chk("rst_done_iid", done_iid, 0);
      chk("rst_row_open", row_open, 0);
      chk("rst_open_row", open_row, 0);
      chk("rst_readies", {w_ready, r_ready}, 0);
      rst_n = 1'b1;
      tick;

      // bank closed
      issue(0, 19'h00400, 5'd3, lat, ro, orow);
      chk("c1_latency", lat, 55);
      chk("c1_row_open", ro, 1);
      chk("c1_open_row", orow, 9'h001);
      chk("c1_is_read", done_is_read, 0);
      chk("c1_iid", done_iid, 3);
      tick;

      // row hit
      issue(1, 19'h007FC, 5'd9, lat, ro, orow);
      chk("c2_latency", lat, 10);
      chk("c2_is_read", done_is_read, 1);
      chk("c2_iid", done_iid, 9);
      tick;

      // row miss
      issue(1, 19'h40000, 5'd2, lat, ro, orow);
      chk("c3_latency", lat, 105);
      chk("c3_open_row", orow, 9'h100);
      chk("c3_iid", done_iid, 2);
      tick;

      // round-robin with both valids held
      rst_n = 1'b0; tick; rst_n = 1'b1; tick;
      w_valid = 1'b1; w_addr = 19'h00400; w_iid = 5'd5;
      r_valid = 1'b1; r_addr = 19'h007FC; r_iid = 4'd6;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         #1;
         while (!(w_ready || r_ready) && n < 300) begin
            tick; #1; n++;
         end
         chk("arb_exclusive", w_ready & r_ready, 0);
         chk("arb_w_grant", w_ready, (g % 2 == 0));
         chk("arb_r_grant", r_ready, (g % 2 == 1));
         tick; #1;
         chk("arb_pulse", {w_ready, r_ready}, 0);
      end

      // backpressure on the last (read, iid 6) completion
      done_ready = 1'b0;
      n = 0;
      while (!done_valid && n < 300) begin
         tick; #1; n++;
      end
      for (int k = 0; k < 7; k++) begin
         chk("bp_done_valid", done_valid, 1);
         chk("bp_done_iid", done_iid, 6);
         chk("bp_is_read", done_is_read, 1);
         chk("bp_readies", {w_ready, r_ready}, 0);
         tick; #1;
      end
      done_ready = 1'b1;
      tick; #1;
      chk("bp_release_w", w_ready, 1);
      chk("bp_release_r", r_ready, 0);
      tick;
      w_valid = 1'b0;
      r_valid = 1'b0;

      // reset mid-SERVE
      repeat (5) tick;
      rst_n = 1'b0;
      #1;
      chk("mr_done_valid", done_valid, 0);
      chk("mr_row_open", row_open, 0);
      chk("mr_open_row", open_row, 0);
      chk("mr_done_iid", done_iid, 0);
      tick;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 120; k++) begin
         tick;
         if (done_valid) seen = 1'b1;
      end
      chk("mr_no_completion", seen, 0);
      issue(0, 19'h00400, 5'd7, lat, ro, orow);
      chk("mr_latency", lat, 55);
      chk("mr_row_open", ro, 1);
      chk("mr_iid", done_iid, 7);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/simmem_row_scheduler.md
# simmem_row_scheduler

Sequences all accesses to the simulated memory's single DRAM bank. It arbitrates between write-address and read-address requesters, tracks the open row buffer, and charges each access its row-hit, activation or precharge cost in clock cycles. It then reports completion with the request's internal identifier. It sits between the write/read response banks, which supply internal IDs, and the delay release logic.

## Interface
Parameters:
- GlobalMemCapaW, 19, address width in bits
- RowBufLenW, 10, log2 of row length in bytes
- RowHitCost, 10, cycles for a row-buffer hit; must be ≥3 (elaboration assertion)
- PrechargeCost, 50, cycles to close an open row
- ActivationCost, 45, cycles to open a row
- WIidW, 5, write internal-ID width
- RIidW, 4, read internal-ID width
- Derived: RowIdW = GlobalMemCapaW−RowBufLenW; IidW = max(WIidW,RIidW); CntW = $clog2(PrechargeCost+ActivationCost+RowHitCost+1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  async active-low reset
- Write-address requester:
  - w_valid_i  in  1  write request valid
  - w_ready_o  out  1  write request accepted
  - w_addr_i  in  GlobalMemCapaW  write byte address
  - w_iid_i  in  WIidW  write internal ID
- Read-address requester:
  - r_valid_i  in  1  read request valid
  - r_ready_o  out  1  read request accepted
  - r_addr_i  in  GlobalMemCapaW  read byte address
  - r_iid_i  in  RIidW  read internal ID
- Completion:
  - done_valid_o  out  1  completion valid
  - done_ready_i  in  1  completion consumed
  - done_is_read_o  out  1  1 = read, 0 = write
  - done_iid_o  out  IidW  ID of the completed request, zero-extended
- Status:
  - row_open_o  out  1  a row is open in the bank
  - open_row_o  out  RowIdW  open row, equal to addr[GlobalMemCapaW−1:RowBufLenW]

## Operation
- FSM states:
  - IDLE→SERVE on accept.
  - SERVE→DONE when cnt==0.
  - DONE→IDLE on done_ready_i.
- Ready signals:
  - Both readies are asserted only in IDLE, and at most one per cycle.
  - Ready may depend combinationally on the valids.
  - w_ready_o = IDLE & w_valid_i & (¬r_valid_i | prio==W).
  - r_ready_o = IDLE & r_valid_i & (¬w_valid_i | prio==R).
- Arbitration:
  - Round-robin `prio` flag; reset value is W.
  - On each accept, `prio` becomes the opposite of the class just granted.
  - A lone valid always wins regardless of `prio`.
- Cost of the accepted request's row (row = addr MSBs):
  - Row hit (row_open & row==open_row): RowHitCost.
  - Bank closed (¬row_open): ActivationCost+RowHitCost.
  - Row miss: PrechargeCost+ActivationCost+RowHitCost.
- Cost arithmetic is computed at CntW width with no overflow.
- On the accept edge:
  - cnt ← cost−2.
  - open_row ← row and row_open ← 1.
  - is_read and iid are latched.
- In SERVE, cnt decrements each cycle. At cnt==0 the FSM moves to DONE.
- DONE: done_valid_o=1 with stable done_is_read_o/done_iid_o until done_ready_i. The return to IDLE takes no extra cycle.
- Rows are never closed autonomously: the open row persists across idle periods.
- Requester fields are sampled only on the accept edge. Changes at other times are ignored.

## Timing
- Reset values:
  - done_valid_o=0, done_is_read_o=0, done_iid_o=0.
  - row_open_o=0, open_row_o=0.
  - w_ready_o=r_ready_o=0 unless a valid is present in IDLE.
  - prio=W, state=IDLE, cnt=0.
- Latency:
  - With the handshake at cycle A, done_valid_o rises at cycle A+cost exactly.
  - Minimum issue interval is cost+1 cycles, when done_ready_i is held high.
- Status: row_open_o and open_row_o update on the accept edge, i.e. visible at A+1.
- Backpressure: done_ready_i low holds DONE indefinitely. No request is accepted meanwhile.
- Simultaneous valids in IDLE: exactly one is granted per the rule above. The loser's valid must stay asserted (AXI rule); it is granted at the next IDLE.
- Reset mid-operation: any in-flight request is dropped with no completion and all state returns to reset values. The next access is therefore a bank-closed access.

## Test plan
- After reset, write addr 0x00400, iid 3, accepted at cycle A → done_valid_o at A+55, done_is_read_o=0, done_iid_o=3; row_open_o=1 and open_row_o=0x001 from A+1.
- Following the first case, read addr 0x007FC, iid 9 → row hit: done at A+10, done_is_read_o=1, done_iid_o=9.
- Following the second case, read addr 0x40000, iid 2 → row miss: done at A+105; open_row_o=0x100.
- After reset, w_valid_i and r_valid_i held high together → grant order is W, R, W, R. Each ready pulse lasts one cycle and the two readies are never high in the same cycle.
- done_ready_i held low for 7 cycles in DONE with both valids high → done_valid_o and done_iid_o stay stable and both readies stay 0. After release, IDLE is entered on the next cycle and a grant follows there.
- rst_ni pulsed low mid-SERVE → outputs return to reset values and no completion is issued. A subsequent write to 0x00400 costs 55 cycles.
